// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL / USB / VGA reset sequencer (optional lock watchdog: LOCK_WATCHDOG_EN)
module reset_sequencer #(
    parameter int PLL_RST_CYCLES = 4,
    parameter int STABLE_CYCLES  = 32,
    parameter int VGA_DELAY      = 8,
    parameter int LOCK_TIMEOUT   = 1024
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_pll_locked,
    input  logic       i_soft_req,
    output logic       o_soft_ack,
    output logic       o_pll_reset,
    output logic       o_reset_usb,
    output logic       o_reset_vga,
    output logic       o_ready,
    output logic [3:0] o_retries
);

    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_USB_UP    = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

`ifdef LOCK_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    // The timeout only widens the counter when the watchdog is built in.
    localparam int WD_SPAN = WDOG_EN ? LOCK_TIMEOUT : 1;
    localparam int MAX_A   = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
    localparam int MAX_B   = (MAX_A > VGA_DELAY) ? MAX_A : VGA_DELAY;
    localparam int CNT_MAX = (MAX_B > WD_SPAN) ? MAX_B : WD_SPAN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] VGA_LAST    = CNT_W'(VGA_DELAY - 1);
`ifdef LOCK_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    logic             r_lock_meta;
    logic             r_lock_s;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_soft_pend;
    logic             r_soft_ack;
    logic             r_pll_reset;
    logic             r_reset_usb;
    logic             r_reset_vga;
    logic             r_ready;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pend_nxt;
    logic             w_ack_nxt;
`ifdef LOCK_WATCHDOG_EN
    logic             w_retry;
    logic [3:0]       r_retries;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= i_pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next-state, counter and soft-reset bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_pend_nxt  = r_soft_pend;
        w_ack_nxt   = 1'b0;
`ifdef LOCK_WATCHDOG_EN
        w_retry     = 1'b0;
`endif
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == PLL_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
`ifndef LOCK_WATCHDOG_EN
                w_cnt_nxt = '0;
`endif
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end
`ifdef LOCK_WATCHDOG_EN
                else if (r_cnt == WD_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_cnt_nxt   = '0;
                    w_retry     = 1'b1;
                end
`endif
            end
            S_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_USB_UP;
                    w_cnt_nxt   = '0;
                end
            end
            S_USB_UP: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == VGA_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    // Completing a host-requested sequence: acknowledge once.
                    if (r_soft_pend) begin
                        w_ack_nxt  = 1'b1;
                        w_pend_nxt = 1'b0;
                    end
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!r_lock_s) begin
                    // Lock loss has priority, but a coincident request is remembered.
                    w_state_nxt = S_WAIT_LOCK;
                    w_pend_nxt  = r_soft_pend | i_soft_req;
                end else if (i_soft_req) begin
                    w_state_nxt = S_STABLE;
                    w_pend_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_soft_pend <= 1'b0;
            r_soft_ack  <= 1'b0;
            r_pll_reset <= 1'b1;
            r_reset_usb <= 1'b1;
            r_reset_vga <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_soft_pend <= w_pend_nxt;
            r_soft_ack  <= w_ack_nxt;
            r_pll_reset <= (w_state_nxt == S_PLL_RST);
            r_reset_usb <= !((w_state_nxt == S_USB_UP) || (w_state_nxt == S_RUN));
            r_reset_vga <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
        end
    end

`ifdef LOCK_WATCHDOG_EN
    // Saturating count of lock watchdog timeouts.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_retries <= 4'd0;
        end else if (w_retry && (r_retries != 4'hF)) begin
            r_retries <= r_retries + 4'd1;
        end
    end

    assign o_retries = r_retries;
`else
    assign o_retries = 4'd0;
`endif

    assign o_soft_ack  = r_soft_ack;
    assign o_pll_reset = r_pll_reset;
    assign o_reset_usb = r_reset_usb;
    assign o_reset_vga = r_reset_vga;
    assign o_ready     = r_ready;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_pll_locked = 1'b0;
    logic       i_soft_req = 1'b0;
    logic       o_soft_ack;
    logic       o_pll_reset;
    logic       o_reset_usb;
    logic       o_reset_vga;
    logic       o_ready;
    logic [3:0] o_retries;

    int n_checks = 0;
    int n_fail   = 0;
    int g_edge   = 0;

    reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .STABLE_CYCLES (32),
        .VGA_DELAY     (8),
        .LOCK_TIMEOUT  (16)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_pll_locked(i_pll_locked),
        .i_soft_req  (i_soft_req),
        .o_soft_ack  (o_soft_ack),
        .o_pll_reset (o_pll_reset),
        .o_reset_usb (o_reset_usb),
        .o_reset_vga (o_reset_vga),
        .o_ready     (o_ready),
        .o_retries   (o_retries)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, g_edge, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        g_edge++;
    endtask

    task automatic wait_to(input int n);
        while (g_edge < n) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        check_eq({tag, "_pll"},   32'(o_pll_reset), 32'd1);
        check_eq({tag, "_usb"},   32'(o_reset_usb), 32'd1);
        check_eq({tag, "_vga"},   32'(o_reset_vga), 32'd1);
        check_eq({tag, "_ready"}, 32'(o_ready),     32'd0);
        check_eq({tag, "_ack"},   32'(o_soft_ack),  32'd0);
        check_eq({tag, "_retr"},  32'(o_retries),   32'd0);
    endtask

    // Hold reset a few cycles, release it #1 after an edge; that edge becomes edge 0.
    task automatic do_reset();
        i_reset_n = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
        g_edge = 0;
    endtask

    initial begin
        // Power-up
        step();
        chk_reset_vals("rst");
        do_reset();
        wait_to(3);  check_eq("pu_pll_e3", 32'(o_pll_reset), 32'd1);
        wait_to(4);  check_eq("pu_pll_e4", 32'(o_pll_reset), 32'd0);
        wait_to(9);  i_pll_locked = 1'b1;                      // sampled at edge 10
        wait_to(43); check_eq("pu_usb_e43", 32'(o_reset_usb), 32'd1);
        wait_to(44); check_eq("pu_usb_e44", 32'(o_reset_usb), 32'd0);
                     check_eq("pu_vga_e44", 32'(o_reset_vga), 32'd1);
        wait_to(51); check_eq("pu_rdy_e51", 32'(o_ready), 32'd0);
        wait_to(52); check_eq("pu_rdy_e52", 32'(o_ready), 32'd1);
                     check_eq("pu_vga_e52", 32'(o_reset_vga), 32'd0);
                     check_eq("pu_ack_e52", 32'(o_soft_ack), 32'd0);

        // Lock loss in RUN (fall sampled at edge 60)
        wait_to(59); i_pll_locked = 1'b0;
        wait_to(61); check_eq("ll_rdy_e61", 32'(o_ready), 32'd1);
        wait_to(62); check_eq("ll_usb_e62", 32'(o_reset_usb), 32'd1);
                     check_eq("ll_vga_e62", 32'(o_reset_vga), 32'd1);
                     check_eq("ll_rdy_e62", 32'(o_ready), 32'd0);
                     check_eq("ll_pll_e62", 32'(o_pll_reset), 32'd0);

        // Re-lock at edge 70, then 3-cycle glitch at edges 80..82 during STABLE
        wait_to(69); i_pll_locked = 1'b1;
        wait_to(79); i_pll_locked = 1'b0;
        wait_to(82); i_pll_locked = 1'b1;                      // returns at edge 83
        wait_to(104); check_eq("gl_usb_e104", 32'(o_reset_usb), 32'd1);
                      check_eq("gl_pll_e104", 32'(o_pll_reset), 32'd0);
        wait_to(116); check_eq("gl_usb_e116", 32'(o_reset_usb), 32'd1);
        wait_to(117); check_eq("gl_usb_e117", 32'(o_reset_usb), 32'd0);
        wait_to(124); check_eq("gl_rdy_e124", 32'(o_ready), 32'd0);
        wait_to(125); check_eq("gl_rdy_e125", 32'(o_ready), 32'd1);

        // Soft reset sampled at edge 130, held one cycle past the ack
        wait_to(129); i_soft_req = 1'b1;
        wait_to(130); check_eq("sr_usb_e130", 32'(o_reset_usb), 32'd1);
                      check_eq("sr_vga_e130", 32'(o_reset_vga), 32'd1);
                      check_eq("sr_rdy_e130", 32'(o_ready), 32'd0);
        wait_to(169); check_eq("sr_ack_e169", 32'(o_soft_ack), 32'd0);
        wait_to(170); check_eq("sr_ack_e170", 32'(o_soft_ack), 32'd1);
                      check_eq("sr_rdy_e170", 32'(o_ready), 32'd1);
        wait_to(171); check_eq("sr2_ack_e171", 32'(o_soft_ack), 32'd0);
                      check_eq("sr2_rdy_e171", 32'(o_ready), 32'd0);
                      check_eq("sr2_usb_e171", 32'(o_reset_usb), 32'd1);
        i_soft_req = 1'b0;
        wait_to(210); check_eq("sr2_ack_e210", 32'(o_soft_ack), 32'd0);
        wait_to(211); check_eq("sr2_ack_e211", 32'(o_soft_ack), 32'd1);
        wait_to(212); check_eq("sr2_ack_e212", 32'(o_soft_ack), 32'd0);
                      check_eq("sr2_rdy_e212", 32'(o_ready), 32'd1);
        wait_to(213); check_eq("sr2_rdy_e213", 32'(o_ready), 32'd1);

        // Async reset during USB_UP (soft sequence from edge 220, USB_UP 252..259)
        wait_to(219); i_soft_req = 1'b1;
        wait_to(220); i_soft_req = 1'b0;
        wait_to(255); check_eq("ar_usb_e255", 32'(o_reset_usb), 32'd0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk_reset_vals("ar_async");
        do_reset();
        wait_to(4);  check_eq("ar_pll_e4", 32'(o_pll_reset), 32'd0);
        wait_to(36); check_eq("ar_usb_e36", 32'(o_reset_usb), 32'd1);
        wait_to(37); check_eq("ar_usb_e37", 32'(o_reset_usb), 32'd0);
        wait_to(44); check_eq("ar_rdy_e44", 32'(o_ready), 32'd0);
        wait_to(45); check_eq("ar_rdy_e45", 32'(o_ready), 32'd1);
                     check_eq("ar_ack_e45", 32'(o_soft_ack), 32'd0);

        // Lock never arrives
        i_pll_locked = 1'b0;
        do_reset();
`ifdef LOCK_WATCHDOG_EN
        wait_to(19);  check_eq("wd_pll_e19",  32'(o_pll_reset), 32'd0);
                      check_eq("wd_ret_e19",  32'(o_retries),   32'd0);
        wait_to(20);  check_eq("wd_pll_e20",  32'(o_pll_reset), 32'd1);
                      check_eq("wd_ret_e20",  32'(o_retries),   32'd1);
        wait_to(24);  check_eq("wd_pll_e24",  32'(o_pll_reset), 32'd0);
        wait_to(40);  check_eq("wd_pll_e40",  32'(o_pll_reset), 32'd1);
                      check_eq("wd_ret_e40",  32'(o_retries),   32'd2);
        wait_to(300); check_eq("wd_ret_e300", 32'(o_retries),   32'd15);
        wait_to(340); check_eq("wd_ret_e340", 32'(o_retries),   32'd15);
                      check_eq("wd_pll_e340", 32'(o_pll_reset), 32'd1);
`else
        wait_to(20);  check_eq("nw_pll_e20",  32'(o_pll_reset), 32'd0);
        wait_to(100); check_eq("nw_pll_e100", 32'(o_pll_reset), 32'd0);
        wait_to(340); check_eq("nw_pll_e340", 32'(o_pll_reset), 32'd0);
                      check_eq("nw_ret_e340", 32'(o_retries),   32'd0);
                      check_eq("nw_usb_e340", 32'(o_reset_usb), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
